// File: rtl/fe_fft_pkg.sv
// Shared FFT front-end definitions: transform size, I/Q slot indices and bin-index width.
package fe_fft_pkg;

  localparam int NFFT    = 64;
  localparam int IDX_I   = 0;
  localparam int IDX_Q   = 1;
  localparam int NBW_DEF = 13;

  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int BIN_W = clog2(NFFT);

  // Complex sample at the default FFT output width, laid out as [1:0] = {Q, I}.
  typedef logic signed [NBW_DEF-1:0] sample_t;
  typedef struct packed {
    sample_t q;
    sample_t i;
  } cplx_t;

endpackage

// File: rtl/fft64_frame_buf.sv
// One captured FFT frame with a LANES-wide beat read mux.
// Capture lands on the edge where i_cap is high; the read path is purely combinational.
module fft64_frame_buf
  import fe_fft_pkg::*;
#(
  parameter int NBW_IN = 13,
  parameter int LANES  = 4,
  parameter int CNT_W  = 4
) (
  input  logic                                 clk,
  input  logic                                 i_cap,
  input  logic [NFFT-1:0][1:0][NBW_IN-1:0]     i_data,
  input  logic [CNT_W-1:0]                     i_beat,
  output logic [LANES-1:0][1:0][NBW_IN-1:0]    o_data
);

  logic [NFFT-1:0][1:0][NBW_IN-1:0] r_buf;

  // Storage only; contents are meaningless until the owning full flag is set.
  always_ff @(posedge clk) begin
    if (i_cap) r_buf <= i_data;
  end

  assign o_data = r_buf[int'(i_beat) * LANES +: LANES];

endmodule

// File: rtl/fft64_bin_serializer.sv
// Ping-pong capture of one-shot 64-bin FFT frames, streamed out LANES bins per beat.
// First beat one cycle after capture; holds under i_ready=0 and drops (sticky flag) a frame only when both buffers are full.
module fft64_bin_serializer
  import fe_fft_pkg::*;
#(
  parameter int NBW_IN = 13,
  parameter int NBI_IN = 6,
  parameter int LANES  = 4
) (
  input  logic                              clk,
  input  logic                              rst_async_n,
  input  logic                              i_valid,
  input  logic [NFFT-1:0][1:0][NBW_IN-1:0]  i_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [LANES-1:0][1:0][NBW_IN-1:0] o_data,
  output logic [BIN_W-1:0]                  o_bin_idx,
  output logic                              o_sof,
  output logic                              o_eof,
  output logic                              o_overflow,
  input  logic                              i_clr_ovf
);

  localparam int NBEATS = NFFT / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? clog2(NBEATS) : 1;

  if (LANES < 1 || LANES > NFFT || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("fft64_bin_serializer: LANES must be a power of two between 1 and 64");
  end
  if (NBI_IN > NBW_IN) begin : g_bad_nbi
    $error("fft64_bin_serializer: NBI_IN exceeds NBW_IN");
  end

  logic [1:0]       r_full;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_acc;
  logic             w_last;
  logic             w_done;
  logic             w_cap;
  logic             w_drop;
  logic [1:0]       w_full_nxt;
  logic [LANES-1:0][1:0][NBW_IN-1:0] w_dat0;
  logic [LANES-1:0][1:0][NBW_IN-1:0] w_dat1;

  assign o_valid = r_full[r_rd_sel];
  assign w_acc   = o_valid & i_ready;
  assign w_last  = (r_cnt == CNT_W'(NBEATS - 1));
  assign w_done  = w_acc & w_last;

  // A buffer freed by its last beat on this edge may be refilled on the same edge.
  assign w_cap  = i_valid & (~r_full[r_wr_sel] | (w_done & (r_rd_sel == r_wr_sel)));
  assign w_drop = i_valid & ~w_cap;

  always_comb begin
    w_full_nxt = r_full;
    if (w_done) w_full_nxt[r_rd_sel] = 1'b0;
    if (w_cap)  w_full_nxt[r_wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_cap) r_wr_sel <= ~r_wr_sel;
      if (w_acc) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_rd_sel <= ~r_rd_sel;
      end
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  fft64_frame_buf #(.NBW_IN(NBW_IN), .LANES(LANES), .CNT_W(CNT_W)) u_buf0 (
    .clk    (clk),
    .i_cap  (w_cap & ~r_wr_sel),
    .i_data (i_data),
    .i_beat (r_cnt),
    .o_data (w_dat0)
  );

  fft64_frame_buf #(.NBW_IN(NBW_IN), .LANES(LANES), .CNT_W(CNT_W)) u_buf1 (
    .clk    (clk),
    .i_cap  (w_cap & r_wr_sel),
    .i_data (i_data),
    .i_beat (r_cnt),
    .o_data (w_dat1)
  );

  assign o_data     = r_rd_sel ? w_dat1 : w_dat0;
  assign o_bin_idx  = BIN_W'(int'(r_cnt) * LANES);
  assign o_sof      = o_valid & (r_cnt == '0);
  assign o_eof      = o_valid & w_last;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_fft64_bin_serializer.sv
// Scoreboard bench for the FFT bin serializer at LANES = 4, 1 and 64.
module tb_fft64_bin_serializer;
  import fe_fft_pkg::*;

  localparam int W = 13;
  typedef logic [NFFT-1:0][1:0][W-1:0] frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n;
  frame_t din;
  logic   vi4, vi1, vi64, rdy4, rdy1, rdy64, clr4;
  logic   vo4, vo1, vo64, sof4, sof1, sof64, eof4, eof1, eof64, ovf4, ovf1, ovf64;
  logic [BIN_W-1:0] idx4, idx1, idx64;
  logic [3:0][1:0][W-1:0] od4;
  logic [0:0][1:0][W-1:0] od1;
  frame_t od64;

  fft64_bin_serializer #(.NBW_IN(W), .NBI_IN(6), .LANES(4)) u_dut4 (
    .clk(clk), .rst_async_n(rst_n), .i_valid(vi4), .i_data(din), .o_valid(vo4),
    .i_ready(rdy4), .o_data(od4), .o_bin_idx(idx4), .o_sof(sof4), .o_eof(eof4),
    .o_overflow(ovf4), .i_clr_ovf(clr4));

  fft64_bin_serializer #(.NBW_IN(W), .NBI_IN(6), .LANES(1)) u_dut1 (
    .clk(clk), .rst_async_n(rst_n), .i_valid(vi1), .i_data(din), .o_valid(vo1),
    .i_ready(rdy1), .o_data(od1), .o_bin_idx(idx1), .o_sof(sof1), .o_eof(eof1),
    .o_overflow(ovf1), .i_clr_ovf(1'b0));

  fft64_bin_serializer #(.NBW_IN(W), .NBI_IN(6), .LANES(64)) u_dut64 (
    .clk(clk), .rst_async_n(rst_n), .i_valid(vi64), .i_data(din), .o_valid(vo64),
    .i_ready(rdy64), .o_data(od64), .o_bin_idx(idx64), .o_sof(sof64), .o_eof(eof64),
    .o_overflow(ovf64), .i_clr_ovf(1'b0));

  int n_chk = 0;
  int n_err = 0;
  bit rnd_rdy = 1'b0;
  frame_t q4[$], q1[$], q64[$];
  frame_t hf4, hf1, hf64;
  int eb4 = 0, eb1 = 0, acc4 = 0, acc1 = 0, acc64 = 0;
  int a0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Bin k carries I = a*k+b, Q = -(a*k+b), wrapped to the sample width.
  function automatic frame_t mk(input int a, input int b);
    frame_t f;
    for (int k = 0; k < NFFT; k++) begin
      f[k][IDX_I] = W'(a * k + b);
      f[k][IDX_Q] = W'(-(a * k + b));
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy4 = 1'($urandom_range(0, 1));
  endtask

  task automatic drv(input int which, input frame_t f, input bit keep);
    din = f;
    case (which)
      1:       begin vi1  = 1'b1; if (keep) q1.push_back(f);  end
      64:      begin vi64 = 1'b1; if (keep) q64.push_back(f); end
      default: begin vi4  = 1'b1; if (keep) q4.push_back(f);  end
    endcase
    tick();
    vi1 = 1'b0; vi4 = 1'b0; vi64 = 1'b0;
  endtask

  task automatic drain4(input int budget);
    int n = 0;
    while (q4.size() != 0 && n < budget) begin tick(); n++; end
    chk("drain4", 128'(q4.size()), 128'(0));
  endtask

  task automatic wait_room4(input int budget);
    int n = 0;
    while (q4.size() >= 2 && n < budget) begin tick(); n++; end
    chk("room4", 128'(q4.size() < 2), 128'(1));
  endtask

  // Every cycle with o_valid is compared against the head frame; this also pins outputs during stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete(); eb4 = 0;
    end else begin
      if (eb4 != 0) chk("vld_mid4", vo4, 1'b1);
      if (vo4) begin
        if (q4.size() == 0) chk("unexp4", vo4, 1'b0);
        else begin
          hf4 = q4[0];
          chk("idx4", idx4, 128'(eb4 * 4));
          chk("sof4", sof4, 128'(eb4 == 0));
          chk("eof4", eof4, 128'(eb4 == 15));
          chk("dat4", od4, hf4[eb4 * 4 +: 4]);
          if (rdy4) begin
            acc4++;
            if (eb4 == 15) begin void'(q4.pop_front()); eb4 = 0; end
            else eb4++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete(); eb1 = 0;
    end else if (vo1) begin
      if (q1.size() == 0) chk("unexp1", vo1, 1'b0);
      else begin
        hf1 = q1[0];
        chk("idx1", idx1, 128'(eb1));
        chk("sof1", sof1, 128'(eb1 == 0));
        chk("eof1", eof1, 128'(eb1 == 63));
        chk("dat1", od1, hf1[eb1]);
        if (rdy1) begin
          acc1++;
          if (eb1 == 63) begin void'(q1.pop_front()); eb1 = 0; end
          else eb1++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q64.delete();
    end else if (vo64) begin
      if (q64.size() == 0) chk("unexp64", vo64, 1'b0);
      else begin
        hf64 = q64[0];
        chk("idx64", idx64, 128'(0));
        chk("sof64", sof64, 1'b1);
        chk("eof64", eof64, 1'b1);
        for (int b = 0; b < NFFT; b++) chk("dat64", od64[b], hf64[b]);
        if (rdy64) begin acc64++; void'(q64.pop_front()); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vi4 = 1'b0; vi1 = 1'b0; vi64 = 1'b0;
    rdy4 = 1'b0; rdy1 = 1'b1; rdy64 = 1'b1; clr4 = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld4", vo4, 1'b0);
    chk("rst_idx4", idx4, 128'(0));
    chk("rst_sof4", sof4, 1'b0);
    chk("rst_eof4", eof4, 1'b0);
    chk("rst_ovf4", ovf4, 1'b0);
    chk("rst_vld1", vo1, 1'b0);
    chk("rst_vld64", vo64, 1'b0);
    rst_n = 1'b1;
    tick();

    // T1: single frame, always ready
    rdy4 = 1'b1;
    a0 = acc4;
    drv(4, mk(1, 0), 1'b1);
    chk("t1_lat_vld", vo4, 1'b1);
    chk("t1_lat_sof", sof4, 1'b1);
    repeat (16) tick();
    chk("t1_beats", 128'(acc4 - a0), 128'(16));
    chk("t1_end_vld", vo4, 1'b0);

    // T2: random backpressure, frames issued whenever a buffer is free
    rnd_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_room4(300);
      drv(4, mk(3 + f, 17 * f + 5), 1'b1);
    end
    drain4(600);
    rnd_rdy = 1'b0;
    chk("t2_ovf", ovf4, 1'b0);

    // T3: stalled consumer, third frame dropped
    rdy4 = 1'b0;
    drv(4, mk(2, 100), 1'b1);
    tick();
    drv(4, mk(-3, 7), 1'b1);
    tick();
    chk("t3_ovf_pre", ovf4, 1'b0);
    drv(4, mk(11, -40), 1'b0);
    chk("t3_ovf_set", ovf4, 1'b1);
    a0 = acc4;
    rdy4 = 1'b1;
    repeat (32) tick();
    chk("t3_beats", 128'(acc4 - a0), 128'(32));
    chk("t3_end_vld", vo4, 1'b0);
    chk("t3_ovf_hold", ovf4, 1'b1);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("t3_ovf_clr", ovf4, 1'b0);

    // T4: drop with clear in the same cycle, then free/capture on the same edge
    rdy4 = 1'b0;
    drv(4, mk(5, 1), 1'b1);
    drv(4, mk(-7, 300), 1'b1);
    clr4 = 1'b1;
    drv(4, mk(9, 9), 1'b0);
    clr4 = 1'b0;
    chk("t4_set_wins", ovf4, 1'b1);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("t4_ovf_clr", ovf4, 1'b0);
    a0 = acc4;
    rdy4 = 1'b1;
    repeat (15) tick();
    drv(4, mk(13, -2), 1'b1);
    chk("t4_no_drop", ovf4, 1'b0);
    drain4(100);
    chk("t4_beats", 128'(acc4 - a0), 128'(48));
    chk("t4_ovf_end", ovf4, 1'b0);

    // T5: reset at beat 7, i_valid ignored while in reset
    drv(4, mk(4, 33), 1'b1);
    repeat (7) tick();
    chk("t5_idx7", idx4, 128'(28));
    rst_n = 1'b0;
    vi4 = 1'b1;
    #1;
    chk("t5_rst_vld", vo4, 1'b0);
    chk("t5_rst_idx", idx4, 128'(0));
    tick();
    tick();
    vi4 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t5_idle_vld", vo4, 1'b0);
    drv(4, mk(6, -9), 1'b1);
    chk("t5_new_sof", sof4, 1'b1);
    chk("t5_new_idx", idx4, 128'(0));
    drain4(40);

    // T6: single-lane and full-width variants
    drv(64, mk(5, 9), 1'b1);
    chk("t6_64_sofeof", 128'(sof64 & eof64), 128'(1));
    tick();
    tick();
    chk("t6_64_beats", 128'(acc64), 128'(1));
    chk("t6_64_vld", vo64, 1'b0);
    a0 = acc1;
    drv(1, mk(7, -100), 1'b1);
    repeat (64) tick();
    chk("t6_1_beats", 128'(acc1 - a0), 128'(64));
    chk("t6_1_vld", vo1, 1'b0);
    chk("t6_1_q", 128'(q1.size()), 128'(0));
    chk("t6_ovf1", ovf1, 1'b0);
    chk("t6_ovf64", ovf64, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
